dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the processor's MEM-stage DMEM port and a multi-cycle word-wide backing memory.
- Performs byte/halfword extraction, sign extension and store byte-lane generation in big-endian order (byte 0 = bits [0:7]).
- Asserts a stall while a refill or write-through is outstanding.

Parameters:
- INDEX_BITS, 6, number of lines = 2^INDEX_BITS.
- OFFSET_BITS, 2, words per line = 2^OFFSET_BITS.
- Tag width is 30 - INDEX_BITS - OFFSET_BITS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- proc_addr  in  [0:31]  byte address from MEM stage
- proc_re  in  1  load request
- proc_we  in  1  store request
- proc_byte  in  1  byte access
- proc_half  in  1  halfword access
- proc_sext  in  1  sign-extend sub-word load
- proc_wdata  in  [0:31]  store data, right-aligned in bits [24:31] / [16:31]
- proc_rdata  out  [0:31]  load result
- stall  out  1  hold pipeline
- mem_req  out  1  backing-memory request
- mem_we  out  1  write request
- mem_addr  out  [0:31]  word-aligned address, bits [30:31] = 0
- mem_be  out  [0:3]  byte enables, mem_be[0] = bits [0:7]
- mem_wdata  out  [0:31]  write data
- mem_rdata  in  [0:31]  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Clears all valid bits; FSM to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - stall=0 and proc_rdata=0 while no access is presented.
- Address split:
  - offset = addr[30:31]; word = addr[30-OFFSET_BITS:29].
  - index = next INDEX_BITS; tag = remaining upper bits.
- Priority: proc_we=1 takes precedence over proc_re, so the access is a store.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, load hit (valid and tag match):
  - proc_rdata combinational, same cycle; stall=0.
  - Byte: selects bits [8*off : 8*off+7].
  - Halfword: addr[30] selects the half; addr[31] is ignored.
  - Word: addr[30:31] is ignored.
  - Zero- or sign-extends per proc_sext.
- IDLE, load miss:
  - stall=1 combinationally in the same cycle.
  - Next cycle enters REFILL with counter=0 and clears the line's valid bit.
- REFILL:
  - mem_req=1, mem_we=0, mem_be=4'b1111.
  - mem_addr = {tag, index, counter, 2'b00}.
  - On each mem_ack: write mem_rdata to word[counter] and increment counter.
  - On ack of the last word: set tag and valid, return to IDLE.
  - The access then hits on the following cycle, so minimum miss penalty = N acks + 1 cycle.
  - stall=1 throughout REFILL.
- IDLE, store (hit or miss):
  - stall=1 combinationally.
  - Latches address, byte enables and lane-shifted data; next cycle enters WRITE.
  - Byte enables: byte → 1 lane; half → lanes {0,1} or {2,3}; word → 4'b1111.
- WRITE:
  - mem_req=1, mem_we=1; holds the latched values.
  - On mem_ack: if the line is valid and the tag matches, merge the enabled lanes into the cached word.
  - Then go to a one-cycle release: stall=0 for the latched store and the FSM ignores proc_we that cycle, so the store is not reissued.
  - Store miss does not allocate.
- mem_ack in IDLE is ignored.
- mem_req stays high until ack; address and data are stable while mem_req=1.
- Reset mid-REFILL or mid-WRITE:
  - Immediately returns to IDLE and deasserts mem_req.
  - Clears all valids, so the partial line is never valid.
- Counter wraps only via completion; there are no partial-line hits during refill.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds output ports hit_count [0:31] and miss_count [0:31].
  - Counters reset to 0.
  - Each counts once per access on the first cycle the access is presented in IDLE.
  - Loads and stores are both counted; store hit = tag match.
  - Counters wrap modulo 2^32.
- When undefined, these ports and their logic are absent.

Test Plan:
- Cold load: word at 0x00000104; memory returns 0x11223344 etc. for 0x100–0x10C → exactly 4 reads at 0x100, 0x104, 0x108, 0x10C; then proc_rdata=0x55667788 (word 1), stall drops.
- Sub-word loads after fill, word 0x80FF7F01 at 0x100:
  - byte addr 0x101 sext → 0xFFFFFFFF.
  - byte addr 0x103 zext → 0x00000001.
  - half addr 0x102 sext → 0x00007F01.
  - half addr 0x100 sext → 0xFFFF80FF.
  - All with stall=0.
- Store hit: byte store 0xAB to 0x102 → mem_be=4'b0010, mem_wdata bits [16:23]=0xAB; after ack, load 0x100 → 0x80FFAB01.
- Store miss to 0x2000 → one write, no refill; subsequent load 0x2000 misses and refills.
- Conflict: load 0x100 then load 0x100 + (4 << (INDEX_BITS+OFFSET_BITS)) → second evicts; reload of 0x100 misses again.
- Reset asserted during the 2nd refill ack wait → mem_req=0 next cycle; load of the same address afterwards misses and refills from word 0.

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache with big-endian sub-word handling.
// Define DCACHE_STATS_EN to add the hit_count/miss_count access counters.
module dcache_dm #(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] proc_addr,
    input  logic        proc_re,
    input  logic        proc_we,
    input  logic        proc_byte,
    input  logic        proc_half,
    input  logic        proc_sext,
    input  logic [0:31] proc_wdata,
    output logic [0:31] proc_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:3]  mem_be,
    output logic [0:31] mem_wdata,
    input  logic [0:31] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [0:31] hit_count,
    output logic [0:31] miss_count
`endif
);

    localparam int unsigned TAG_W = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned DEPTH = 1 << (INDEX_BITS + OFFSET_BITS);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                   state;
    logic [0:TAG_W-1]         tag_mem [LINES];
    logic [0:31]              data_mem [DEPTH];
    logic [0:LINES-1]         valid;

    logic [0:TAG_W-1]         a_tag;
    logic [INDEX_BITS-1:0]    a_idx;
    logic [OFFSET_BITS-1:0]   a_word;
    logic [0:1]               a_off;

    logic [0:TAG_W-1]         acc_tag;
    logic [INDEX_BITS-1:0]    acc_idx;
    logic [OFFSET_BITS-1:0]   acc_word;
    logic [OFFSET_BITS-1:0]   cnt;
    logic [OFFSET_BITS-1:0]   cnt_next;
    // Set when leaving IDLE; the access still presented on return is the one already serviced.
    logic                     resume;

    logic        hit, store_go, load_go, miss_go, store_hit_w;
    logic [0:31] rd_word, ld_ext, merged, st_data;
    logic [0:7]  ld_byte;
    logic [0:15] ld_half;
    logic [0:3]  st_be;

    assign a_tag    = proc_addr[0 +: TAG_W];
    assign a_idx    = proc_addr[TAG_W +: INDEX_BITS];
    assign a_word   = proc_addr[TAG_W + INDEX_BITS +: OFFSET_BITS];
    assign a_off    = proc_addr[30:31];
    assign cnt_next = cnt + 1'b1;

    assign hit         = valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign store_go    = proc_we && !resume;
    assign load_go     = proc_re && !proc_we;
    assign miss_go     = load_go && !hit;
    assign store_hit_w = valid[acc_idx] && (tag_mem[acc_idx] == acc_tag);
    assign stall       = (state != IDLE) || store_go || miss_go;

    always_comb begin
        rd_word = data_mem[{a_idx, a_word}];
        ld_byte = rd_word[{a_off, 3'b000} +: 8];
        ld_half = rd_word[{a_off[0], 4'b0000} +: 16];
        if (proc_byte)
            ld_ext = proc_sext ? {{24{ld_byte[0]}}, ld_byte} : {24'h000000, ld_byte};
        else if (proc_half)
            ld_ext = proc_sext ? {{16{ld_half[0]}}, ld_half} : {16'h0000, ld_half};
        else
            ld_ext = rd_word;
        proc_rdata = (state == IDLE && load_go && hit) ? ld_ext : '0;
    end

    always_comb begin
        st_be   = '0;
        st_data = '0;
        if (proc_byte) begin
            st_be[a_off]                      = 1'b1;
            st_data[{a_off, 3'b000} +: 8]     = proc_wdata[24:31];
        end else if (proc_half) begin
            st_be[{a_off[0], 1'b0} +: 2]      = 2'b11;
            st_data[{a_off[0], 4'b0000} +: 16] = proc_wdata[16:31];
        end else begin
            st_be   = '1;
            st_data = proc_wdata;
        end
    end

    always_comb begin
        merged = data_mem[{acc_idx, acc_word}];
        for (int unsigned i = 0; i < 4; i++)
            if (mem_be[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            resume    <= 1'b0;
            acc_tag   <= '0;
            acc_idx   <= '0;
            acc_word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resume <= 1'b0;
                    if (store_go) begin
                        acc_tag   <= a_tag;
                        acc_idx   <= a_idx;
                        acc_word  <= a_word;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {proc_addr[0:29], 2'b00};
                        mem_be    <= st_be;
                        mem_wdata <= st_data;
                        resume    <= 1'b1;
                        state     <= WRITE;
                    end else if (miss_go) begin
                        acc_tag      <= a_tag;
                        acc_idx      <= a_idx;
                        acc_word     <= a_word;
                        valid[a_idx] <= 1'b0;
                        cnt          <= '0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_be       <= '1;
                        mem_addr     <= {a_tag, a_idx, {OFFSET_BITS{1'b0}}, 2'b00};
                        resume       <= 1'b1;
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt_next;
                        if (cnt == '1) begin
                            valid[acc_idx] <= 1'b1;
                            mem_req        <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            mem_addr <= {acc_tag, acc_idx, cnt_next, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == REFILL && mem_ack) begin
                data_mem[{acc_idx, cnt}] <= mem_rdata;
                if (cnt == '1) tag_mem[acc_idx] <= acc_tag;
            end else if (state == WRITE && mem_ack && store_hit_w) begin
                data_mem[{acc_idx, acc_word}] <= merged;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && !resume && (proc_re || proc_we)) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: vector table of loads/stores, a backing-memory model with a
// scoreboard of expected memory transactions, and a reset-during-refill sequence.
module tb_dcache_dm;

    localparam int unsigned IDX = 6;
    localparam int unsigned OFF = 2;
    localparam int          LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [0:31] proc_addr, proc_wdata, proc_rdata;
    logic        proc_re, proc_we, proc_byte, proc_half, proc_sext, stall;
    logic        mem_req, mem_we, mem_ack;
    logic [0:31] mem_addr, mem_wdata, mem_rdata;
    logic [0:3]  mem_be;
`ifdef DCACHE_STATS_EN
    logic [0:31] hit_count, miss_count;
`endif

    dcache_dm #(.INDEX_BITS(IDX), .OFFSET_BITS(OFF)) dut (
        .clock(clock), .reset(reset),
        .proc_addr(proc_addr), .proc_re(proc_re), .proc_we(proc_we),
        .proc_byte(proc_byte), .proc_half(proc_half), .proc_sext(proc_sext),
        .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [0:31] addr;
        logic        we;
        logic [0:3]  be;
        logic [0:31] wdata;
    } memop_t;

    typedef struct {
        bit          st;
        logic [0:31] addr;
        int          sz;     // 0 word, 1 byte, 2 half
        bit          sext;
        bit          miss;
        logic [0:31] data;   // store data driven, or load result required
        logic [0:3]  be;
        logic [0:31] wd;
    } vec_t;

    memop_t      exp_q[$];
    vec_t        vecs[$];
    logic [0:31] mem_words [int unsigned];
    int          checks = 0;
    int          errors = 0;
    int          allowed = -1;
    int          acks = 0;

    function automatic logic [0:31] mem_read(input logic [0:31] a);
        int unsigned k = a >> 2;
        if (mem_words.exists(k)) return mem_words[k];
        return {a[16:31], ~a[16:31]};
    endfunction

    function automatic memop_t mk_op(input logic [0:31] a, input logic we, input logic [0:3] be,
                                     input logic [0:31] wd);
        memop_t o;
        o.addr = a; o.we = we; o.be = be; o.wdata = wd;
        return o;
    endfunction

    function automatic vec_t ld(input logic [0:31] a, input int sz, input bit sext,
                                input bit miss, input logic [0:31] exp);
        vec_t v;
        v.st = 1'b0; v.addr = a; v.sz = sz; v.sext = sext; v.miss = miss;
        v.data = exp; v.be = '0; v.wd = '0;
        return v;
    endfunction

    function automatic vec_t stv(input logic [0:31] a, input int sz, input logic [0:31] d,
                                 input logic [0:3] be, input logic [0:31] wd);
        vec_t v;
        v.st = 1'b1; v.addr = a; v.sz = sz; v.sext = 1'b0; v.miss = 1'b0;
        v.data = d; v.be = be; v.wd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Backing memory: acks each request LAT cycles after it is seen, checking it against the scoreboard.
    initial begin
        int          wait_cnt;
        memop_t      e;
        logic [0:31] mask, w;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req && allowed != 0) begin
                wait_cnt++;
                if (wait_cnt >= LAT) begin
                    wait_cnt = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: addr %h we %b, required no request",
                                 mem_addr, mem_we);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 4; i++) mask[8*i +: 8] = e.be[i] ? 8'hFF : 8'h00;
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                        check("mem_be", {28'd0, mem_be}, {28'd0, e.be});
                        if (e.we) check("mem_wdata", mem_wdata & mask, e.wdata & mask);
                    end
                    if (mem_we) begin
                        w = mem_read(mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                        mem_words[mem_addr >> 2] = w;
                    end else begin
                        mem_rdata = mem_read(mem_addr);
                    end
                    mem_ack = 1'b1;
                    acks++;
                    if (allowed > 0) allowed--;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic access(input logic we, input logic [0:31] addr, input int sz, input logic sext,
                          input logic [0:31] wdata, output logic [0:31] rdata, output int stalls);
        @(posedge clock); #1;
        proc_addr = addr; proc_we = we; proc_re = !we;
        proc_byte = (sz == 1); proc_half = (sz == 2); proc_sext = sext; proc_wdata = wdata;
        stalls = 0;
        @(negedge clock);
        while (stall && stalls < 500) begin
            stalls++;
            @(negedge clock);
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: addr %h still stalled, required release", addr);
        end
        rdata = proc_rdata;
        @(posedge clock); #1;
        proc_re = 1'b0; proc_we = 1'b0; proc_byte = 1'b0; proc_half = 1'b0; proc_sext = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required $finish");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [0:31] rd;
        int          stalls, base, cyc;

        reset = 1'b1;
        proc_addr = '0; proc_wdata = '0;
        proc_re = 1'b0; proc_we = 1'b0; proc_byte = 1'b0; proc_half = 1'b0; proc_sext = 1'b0;
        mem_words[32'h100 >> 2] = 32'h11223344;
        mem_words[32'h104 >> 2] = 32'h55667788;
        mem_words[32'h108 >> 2] = 32'h99AABBCC;
        mem_words[32'h10C >> 2] = 32'hDDEEFF00;

        vecs.push_back(ld (32'h104, 0, 0, 1, 32'h55667788));
        vecs.push_back(ld (32'h10C, 0, 0, 0, 32'hDDEEFF00));
        vecs.push_back(stv(32'h100, 0, 32'h80FF7F01, 4'b1111, 32'h80FF7F01));
        vecs.push_back(ld (32'h100, 0, 0, 0, 32'h80FF7F01));
        vecs.push_back(ld (32'h101, 1, 1, 0, 32'hFFFFFFFF));
        vecs.push_back(ld (32'h103, 1, 0, 0, 32'h00000001));
        vecs.push_back(ld (32'h102, 2, 1, 0, 32'h00007F01));
        vecs.push_back(ld (32'h100, 2, 1, 0, 32'hFFFF80FF));
        vecs.push_back(ld (32'h101, 2, 0, 0, 32'h000080FF));
        vecs.push_back(ld (32'h103, 0, 0, 0, 32'h80FF7F01));
        vecs.push_back(stv(32'h102, 1, 32'h123456AB, 4'b0010, 32'h0000AB00));
        vecs.push_back(ld (32'h100, 0, 0, 0, 32'h80FFAB01));
        vecs.push_back(ld (32'h102, 1, 1, 0, 32'hFFFFFFAB));
        vecs.push_back(stv(32'h106, 2, 32'hDEADBEEF, 4'b0011, 32'h0000BEEF));
        vecs.push_back(ld (32'h104, 0, 0, 0, 32'h5566BEEF));
        vecs.push_back(ld (32'h106, 2, 1, 0, 32'hFFFFBEEF));
        vecs.push_back(stv(32'h2000, 0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D));
        vecs.push_back(ld (32'h2000, 0, 0, 1, 32'hCAFEF00D));
        vecs.push_back(ld (32'h100 + (4 << (IDX + OFF)), 0, 0, 1,
                           mem_read(32'h100 + (4 << (IDX + OFF)))));
        vecs.push_back(ld (32'h100, 0, 0, 1, 32'h80FFAB01));

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_rdata", proc_rdata, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_be", {28'd0, mem_be}, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.st) begin
                exp_q.push_back(mk_op({v.addr[0:29], 2'b00}, 1'b1, v.be, v.wd));
                access(1'b1, v.addr, v.sz, 1'b0, v.data, rd, stalls);
                check($sformatf("store_stall_cycles[%0d]", i), stalls, LAT + 1);
            end else begin
                if (v.miss)
                    for (int w = 0; w < 4; w++)
                        exp_q.push_back(mk_op({v.addr[0:27], 4'b0000} + 32'(4 * w), 1'b0, 4'b1111, '0));
                access(1'b0, v.addr, v.sz, v.sext, '0, rd, stalls);
                check($sformatf("load_data[%0d]", i), rd, v.data);
                check($sformatf("load_stall_cycles[%0d]", i), stalls, v.miss ? 4 * LAT + 1 : 0);
            end
            check($sformatf("sb_drained[%0d]", i), exp_q.size(), 0);
        end

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'd15);
        check("miss_count", miss_count, 32'd5);
`endif

        // Reset while the refill waits for its second word.
        allowed = 1;
        exp_q.push_back(mk_op(32'h300, 1'b0, 4'b1111, '0));
        base = acks;
        @(posedge clock); #1;
        proc_addr = 32'h300; proc_re = 1'b1;
        cyc = 0;
        while (acks == base && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("first_refill_ack", acks - base, 1);
        @(negedge clock);
        check("refill_req_held", {31'd0, mem_req}, 32'd1);
        check("refill_addr_word1", mem_addr, 32'h304);
        check("refill_stall", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1; proc_re = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mem_req_after_reset", {31'd0, mem_req}, 32'd0);
        check("stall_after_reset", {31'd0, stall}, 32'd0);
        allowed = -1;
        for (int w = 0; w < 4; w++)
            exp_q.push_back(mk_op(32'h300 + 32'(4 * w), 1'b0, 4'b1111, '0));
        access(1'b0, 32'h300, 0, 1'b0, '0, rd, stalls);
        check("reload_data", rd, mem_read(32'h300));
        check("reload_stall_cycles", stalls, 4 * LAT + 1);
        check("reload_sb_drained", exp_q.size(), 0);
`ifdef DCACHE_STATS_EN
        check("miss_count_after_reset", miss_count, 32'd1);
        check("hit_count_after_reset", hit_count, 32'd0);
`endif

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
